swipt_lock_ctrl: RTL and testbench



---
 rtl/swipt_lock_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_swipt_lock_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/swipt_lock_ctrl.sv
// swipt_lock_ctrl
// Measures the PLL NCO period from MSB wraps of its phase accumulator,
// declares lock after a run of matching periods and then hands the PLL
// frequency word to the SWIPT output driver. On loss of lock the last good
// word is held and a one-cycle reload request is sent back to the PLL.
//
// Reset (nrst) is synchronous and active-high. The FSM state is exported on
// the state port for observation.
module swipt_lock_ctrl #(
  parameter logic [31:0] DEFAULT_FREQ = 32'h9C40,
  parameter int          PW           = 16,
  parameter int          TOL          = 4,
  parameter int          LOCK_CNT     = 8,
  parameter int          UNLOCK_CNT   = 3,
  parameter int          ACQ_MAX      = 256
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          swipt_alive,
  input  logic [31:0]   phase,
  input  logic [31:0]   freq_in,
  output logic [31:0]   freq_out,
  output logic          lock,
  output logic          reload,
  output logic [PW-1:0] period,
  output logic [1:0]    state
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int AW = $clog2(ACQ_MAX + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t        cur_state;
  state_t        nxt_state;

  logic          msb_d;
  logic [PW-1:0] cnt;
  logic [PW-1:0] prev;
  logic          first_seen;
  logic          prev_valid;
  logic [GW-1:0] good_cnt;
  logic [AW-1:0] acq_cnt;
  logic [BW-1:0] bad_cnt;
  logic          reload_r;

  logic          wrap;
  logic          sat;
  logic          valid;
  logic          cmp;
  logic [PW:0]   diff;
  logic          good;
  logic          good_hit;
  logic          bad_hit;
  logic          lock_hit;
  logic          acq_hit;
  logic          unlock_hit;

  // Only the accumulator MSB matters for wrap detection.
  logic          unused_phase;
  assign unused_phase = ^phase[30:0];

  // A period boundary is the MSB falling from 1 to 0.
  assign wrap  = msb_d & ~phase[31];
  assign sat   = &cnt;
  // The first wrap after (re)starting acquisition only aligns the counter.
  assign valid = wrap & first_seen;
  // A compare needs a previous valid period to compare against.
  assign cmp   = valid & prev_valid;
  assign diff  = (cnt >= prev) ? ({1'b0, cnt} - {1'b0, prev})
                               : ({1'b0, prev} - {1'b0, cnt});
  assign good     = (diff <= (PW+1)'(TOL));
  assign good_hit = cmp & good;
  assign bad_hit  = cmp & ~good;

  // Lock takes priority over the acquisition-timeout reload on the same wrap.
  assign lock_hit   = (cur_state == ACQUIRE) & good_hit &
                      (good_cnt == GW'(LOCK_CNT - 1));
  assign acq_hit    = (cur_state == ACQUIRE) & valid & ~lock_hit &
                      (acq_cnt == AW'(ACQ_MAX - 1));
  assign unlock_hit = (cur_state == LOCKED) &
                      (sat | (bad_hit & (bad_cnt == BW'(UNLOCK_CNT - 1))));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (nrst) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // FSM next-state logic; losing swipt_alive overrides every state.
  always_comb begin
    nxt_state = cur_state;
    if (!swipt_alive) begin
      nxt_state = IDLE;
    end else begin
      case (cur_state)
        IDLE:    nxt_state = ACQUIRE;
        ACQUIRE: if (lock_hit) nxt_state = LOCKED;
        LOCKED:  if (unlock_hit) nxt_state = HOLD;
        HOLD:    nxt_state = ACQUIRE;
        default: nxt_state = IDLE;
      endcase
    end
  end

  // FSM outputs: reload is the HOLD cycle or a registered acquisition timeout.
  always_comb begin
    lock   = (cur_state == LOCKED);
    reload = reload_r | (cur_state == HOLD);
    state  = cur_state;
  end

  // Period measurement, good/bad/acquire counters and the frequency register.
  always_ff @(posedge clk) begin
    if (nrst) begin
      msb_d      <= 1'b0;
      cnt        <= '0;
      prev       <= '0;
      period     <= '0;
      first_seen <= 1'b0;
      prev_valid <= 1'b0;
      good_cnt   <= '0;
      acq_cnt    <= '0;
      bad_cnt    <= '0;
      reload_r   <= 1'b0;
      freq_out   <= DEFAULT_FREQ;
    end else begin
      msb_d    <= phase[31];
      reload_r <= 1'b0;
      if (wrap) begin
        cnt <= PW'(1);
      end else if (!sat) begin
        cnt <= cnt + 1'b1;
      end

      if (!swipt_alive || cur_state == IDLE) begin
        first_seen <= 1'b0;
        prev_valid <= 1'b0;
        good_cnt   <= '0;
        acq_cnt    <= '0;
        bad_cnt    <= '0;
        freq_out   <= DEFAULT_FREQ;
      end else begin
        case (cur_state)
          ACQUIRE: begin
            if (wrap) begin
              if (!first_seen) begin
                first_seen <= 1'b1;
              end else begin
                period     <= cnt;
                prev       <= cnt;
                prev_valid <= 1'b1;
                acq_cnt    <= acq_cnt + 1'b1;
                if (cmp) begin
                  good_cnt <= good ? good_cnt + 1'b1 : '0;
                end
                if (lock_hit) begin
                  freq_out <= freq_in;
                  good_cnt <= '0;
                  acq_cnt  <= '0;
                end else if (acq_hit) begin
                  good_cnt   <= '0;
                  acq_cnt    <= '0;
                  first_seen <= 1'b0;
                  prev_valid <= 1'b0;
                  reload_r   <= 1'b1;
                end
              end
            end
          end
          LOCKED: begin
            if (valid) begin
              period     <= cnt;
              prev       <= cnt;
              prev_valid <= 1'b1;
              if (cmp) begin
                bad_cnt <= good ? '0 : bad_cnt + 1'b1;
              end
            end
            if (unlock_hit) begin
              first_seen <= 1'b0;
              prev_valid <= 1'b0;
              good_cnt   <= '0;
              acq_cnt    <= '0;
              bad_cnt    <= '0;
            end
          end
          HOLD: begin
            first_seen <= 1'b0;
            prev_valid <= 1'b0;
            good_cnt   <= '0;
            acq_cnt    <= '0;
            bad_cnt    <= '0;
          end
          default: begin
            first_seen <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swipt_lock_ctrl.sv
// Directed testbench for swipt_lock_ctrl. The NCO is modelled by driving the
// phase MSB directly: a period of n cycles is n-1 cycles high then 1 low, so
// the wrap falls on the last cycle of each run_period call.
module tb_swipt_lock_ctrl;

  logic        clk;
  logic        nrst;
  logic        swipt_alive;
  logic [31:0] phase;
  logic [31:0] freq_in;
  logic [31:0] freq_out;
  logic        lock;
  logic        reload;
  logic [15:0] period;
  logic [1:0]  state;

  int checks;
  int errors;

  swipt_lock_ctrl dut (
    .clk         (clk),
    .nrst        (nrst),
    .swipt_alive (swipt_alive),
    .phase       (phase),
    .freq_in     (freq_in),
    .freq_out    (freq_out),
    .lock        (lock),
    .reload      (reload),
    .period      (period),
    .state       (state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one cycle with the given phase MSB, return 1 time unit after the edge
  task automatic step(input logic m);
    phase = {m, 31'($urandom)};
    @(posedge clk);
    #1;
  endtask

  task automatic run_period(input int n);
    for (int i = 0; i < n - 1; i++) step(1'b1);
    step(1'b0);
  endtask

  task automatic test_reset;
    nrst = 1'b1; swipt_alive = 1'b0; freq_in = 32'h0; phase = 32'h0;
    step(1'b0); step(1'b0);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (freq_out !== 32'h9C40) begin errors++; $display("FAIL reset_freq: got %h want 00009c40", freq_out); end
    checks++; if (lock !== 1'b0 || reload !== 1'b0) begin errors++; $display("FAIL reset_flags: lock %b reload %b want 0 0", lock, reload); end
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
    nrst = 1'b0;
  endtask

  task automatic test_lock;
    swipt_alive = 1'b1; freq_in = 32'h028F5C29;
    step(1'b0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL lock_enter_acq: got %0d want 1", state); end
    for (int i = 0; i < 9; i++) run_period(100);
    checks++; if (lock !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL lock_early: lock %b state %0d want 0 1", lock, state); end
    checks++; if (freq_out !== 32'h9C40) begin errors++; $display("FAIL lock_acq_freq: got %h want 00009c40", freq_out); end
    run_period(100);
    checks++; if (lock !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL lock_rise: lock %b state %0d want 1 2", lock, state); end
    checks++; if (freq_out !== 32'h028F5C29) begin errors++; $display("FAIL lock_freq: got %h want 028f5c29", freq_out); end
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL lock_period: got %0d want 100", period); end
  endtask

  task automatic test_unlock;
    freq_in = 32'h12345678;
    run_period(150);
    checks++; if (state !== 2'd2 || period !== 16'd150) begin errors++; $display("FAIL unlock_bad1: state %0d period %0d want 2 150", state, period); end
    checks++; if (freq_out !== 32'h028F5C29) begin errors++; $display("FAIL unlock_frozen: got %h want 028f5c29", freq_out); end
    run_period(100);
    checks++; if (state !== 2'd2 || reload !== 1'b0) begin errors++; $display("FAIL unlock_bad2: state %0d reload %b want 2 0", state, reload); end
    run_period(150);
    checks++; if (state !== 2'd3 || lock !== 1'b0 || reload !== 1'b1) begin errors++; $display("FAIL unlock_hold: state %0d lock %b reload %b want 3 0 1", state, lock, reload); end
    checks++; if (freq_out !== 32'h028F5C29) begin errors++; $display("FAIL unlock_hold_freq: got %h want 028f5c29", freq_out); end
    step(1'b1);
    checks++; if (state !== 2'd1 || reload !== 1'b0) begin errors++; $display("FAIL unlock_reacq: state %0d reload %b want 1 0", state, reload); end
    checks++; if (freq_out !== 32'h028F5C29) begin errors++; $display("FAIL unlock_acq_freq: got %h want 028f5c29", freq_out); end
  endtask

  task automatic test_saturate;
    int n;
    freq_in = 32'h028F5C29;
    for (int i = 0; i < 10; i++) run_period(100);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL sat_relock: state %0d want 2", state); end
    n = 0;
    while (state !== 2'd3 && n < 70000) begin
      step(1'b0);
      n++;
    end
    checks++; if (n != 65535) begin errors++; $display("FAIL sat_cycles: got %0d want 65535", n); end
    checks++; if (reload !== 1'b1 || lock !== 1'b0) begin errors++; $display("FAIL sat_hold: reload %b lock %b want 1 0", reload, lock); end
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL sat_period: got %0d want 100", period); end
    step(1'b0);
    checks++; if (state !== 2'd1 || reload !== 1'b0) begin errors++; $display("FAIL sat_reacq: state %0d reload %b want 1 0", state, reload); end
  endtask

  task automatic test_acq_max;
    int early;
    int locked_seen;
    early = 0; locked_seen = 0;
    for (int i = 0; i < 256; i++) begin
      run_period((i % 2) ? 30 : 20);
      if (reload !== 1'b0) early++;
      if (lock !== 1'b0) locked_seen++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL acq_early_reload: got %0d pulses want 0", early); end
    checks++; if (locked_seen != 0) begin errors++; $display("FAIL acq_false_lock: got %0d want 0", locked_seen); end
    run_period(20);
    checks++; if (reload !== 1'b1 || state !== 2'd1) begin errors++; $display("FAIL acq_reload: reload %b state %0d want 1 1", reload, state); end
    checks++; if (period !== 16'd20) begin errors++; $display("FAIL acq_period: got %0d want 20", period); end
    step(1'b1);
    checks++; if (reload !== 1'b0) begin errors++; $display("FAIL acq_reload_width: got %b want 0", reload); end
    for (int i = 0; i < 9; i++) run_period(100);
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL acq_restart_early: lock %b want 0", lock); end
    run_period(100);
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL acq_restart_lock: lock %b want 1", lock); end
  endtask

  task automatic test_alive_drop;
    swipt_alive = 1'b0;
    step(1'b1);
    checks++; if (state !== 2'd0 || lock !== 1'b0 || reload !== 1'b0) begin errors++; $display("FAIL alive_idle: state %0d lock %b reload %b want 0 0 0", state, lock, reload); end
    checks++; if (freq_out !== 32'h9C40) begin errors++; $display("FAIL alive_freq: got %h want 00009c40", freq_out); end
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL alive_period_kept: got %0d want 100", period); end
    swipt_alive = 1'b1; freq_in = 32'h0147AE14;
    step(1'b1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL alive_reacq: state %0d want 1", state); end
    for (int i = 0; i < 9; i++) run_period(100);
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL alive_early_lock: lock %b want 0", lock); end
    run_period(100);
    checks++; if (lock !== 1'b1 || freq_out !== 32'h0147AE14) begin errors++; $display("FAIL alive_relock: lock %b freq %h want 1 0147ae14", lock, freq_out); end
    freq_in = 32'hDEADBEEF;
    step(1'b1);
    checks++; if (freq_out !== 32'h0147AE14) begin errors++; $display("FAIL alive_freeze: got %h want 0147ae14", freq_out); end
  endtask

  task automatic test_reset_mid_acq;
    swipt_alive = 1'b0; step(1'b1);
    swipt_alive = 1'b1; step(1'b1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_setup: state %0d want 1", state); end
    for (int i = 0; i < 3; i++) run_period(100);
    for (int i = 0; i < 99; i++) step(1'b1);
    nrst = 1'b1;
    step(1'b0);
    checks++; if (state !== 2'd0 || lock !== 1'b0 || reload !== 1'b0) begin errors++; $display("FAIL rst_flags: state %0d lock %b reload %b want 0 0 0", state, lock, reload); end
    checks++; if (period !== 16'd0 || freq_out !== 32'h9C40) begin errors++; $display("FAIL rst_values: period %0d freq %h want 0 00009c40", period, freq_out); end
    nrst = 1'b0;
    step(1'b1);
    checks++; if (state !== 2'd1 || reload !== 1'b0) begin errors++; $display("FAIL rst_release: state %0d reload %b want 1 0", state, reload); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_lock;
    test_unlock;
    test_saturate;
    test_acq_max;
    test_alive_drop;
    test_reset_mid_acq;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
